// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider core and its board wrapper.
// State encodings, default operand width and the iteration-counter width.
package div_pkg;

   localparam int N_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_UNUSED = 2'b00,
      ST_IDLE   = 2'b01,
      ST_DIVIDE = 2'b10,
      ST_FIXUP  = 2'b11
   } state_t;

   // The counter must be able to hold N itself, not just N-1.
   function automatic int count_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle of the sequential divider.
// The slave side is the core; the master side is the wrapper or the bench.
interface seq_divider_if #(parameter int N = div_pkg::N_DEFAULT);
   import div_pkg::*;

   localparam int CW = count_w(N);

   logic          start;
   logic [N-1:0]  iDividend;
   logic [N-1:0]  iDivisor;
   logic [N-1:0]  oQuotient;
   logic [N-1:0]  oRemainder;
   logic          Done;
   logic          Busy;
   logic          oDivZero;
   logic          oOverflow;
   logic [1:0]    oState;
   logic [CW-1:0] oCount;

   modport master (
      output start, iDividend, iDivisor,
      input  oQuotient, oRemainder, Done, Busy, oDivZero, oOverflow, oState, oCount
   );

   modport slave (
      input  start, iDividend, iDivisor,
      output oQuotient, oRemainder, Done, Busy, oDivZero, oOverflow, oState, oCount
   );

endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// truncating quotient and dividend-signed remainder applied in a final fix-up cycle.
module seq_divider
   import div_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input logic        Clock,
   input logic        Reset_n,
   seq_divider_if.slave bus
);

   localparam int            CW       = count_w(N);
   localparam logic [CW-1:0] LAST     = CW'(N - 1);
   localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_count;

   logic [N:0]     r_rem_acc;
   logic [N-1:0]   r_q_acc;
   logic [N-1:0]   r_dvs_mag;
   logic [N-1:0]   r_dividend;
   logic           r_sdvd;
   logic           r_qneg;
   logic           r_dz_op;
   logic           r_ovf_op;

   logic [N-1:0]   r_quot;
   logic [N-1:0]   r_rem;
   logic           r_done;
   logic           r_dz;
   logic           r_ovf;

   logic           w_load;
   logic [N:0]     w_shift;
   logic           w_borrow;
   logic [N:0]     w_diff;
   logic           w_fits;

   function automatic logic [N-1:0] mag(input logic [N-1:0] x);
      return x[N-1] ? -x : x;
   endfunction

   assign w_load  = (r_state == ST_IDLE) && bus.start;
   assign w_shift = {r_rem_acc[N-1:0], r_q_acc[N-1]};
   assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, r_dvs_mag};
   // A set top bit of R would make the shifted value exceed any divisor magnitude.
   assign w_fits  = r_rem_acc[N] | ~w_borrow;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (bus.start) w_next = (bus.iDivisor == '0) ? ST_FIXUP : ST_DIVIDE;
         ST_DIVIDE: if (r_count == LAST) w_next = ST_FIXUP;
         ST_FIXUP:  w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_count <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_count <= '0;
                  r_done  <= 1'b0;
                  r_dz    <= 1'b0;
                  r_ovf   <= 1'b0;
               end
            end
            ST_DIVIDE: r_count <= r_count + CW'(1);
            ST_FIXUP: begin
               r_done <= 1'b1;
               r_dz   <= r_dz_op;
               r_ovf  <= r_ovf_op;
               if (r_dz_op) begin
                  r_quot <= '1;
                  r_rem  <= r_dividend;
               end else begin
                  r_quot <= r_qneg ? -r_q_acc : r_q_acc;
                  r_rem  <= r_sdvd ? -r_rem_acc[N-1:0] : r_rem_acc[N-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Working datapath needs no reset: every operation starts by loading it.
   always_ff @(posedge Clock) begin
      if (w_load) begin
         r_rem_acc  <= '0;
         r_q_acc    <= mag(bus.iDividend);
         r_dvs_mag  <= mag(bus.iDivisor);
         r_dividend <= bus.iDividend;
         r_sdvd     <= bus.iDividend[N-1];
         r_qneg     <= bus.iDividend[N-1] ^ bus.iDivisor[N-1];
         r_dz_op    <= (bus.iDivisor == '0);
         r_ovf_op   <= (bus.iDividend == MOST_NEG) && (bus.iDivisor == '1);
      end else if (r_state == ST_DIVIDE) begin
         r_rem_acc <= w_fits ? w_diff : w_shift;
         r_q_acc   <= {r_q_acc[N-2:0], w_fits};
      end
   end

   assign bus.oQuotient  = r_quot;
   assign bus.oRemainder = r_rem;
   assign bus.Done       = r_done;
   assign bus.Busy       = (r_state == ST_DIVIDE) || (r_state == ST_FIXUP);
   assign bus.oDivZero   = r_dz;
   assign bus.oOverflow  = r_ovf;
   assign bus.oState     = r_state;
   assign bus.oCount     = r_count;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: hand-computed vector table, multi-cycle corner sequences,
// and random operands checked against an integer-arithmetic reference.
module tb_seq_divider;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [15:0] prev_q = '0;
   logic [15:0] prev_r = '0;

   always #5 clk = ~clk;

   seq_divider_if #(.N(16)) bus ();

   seq_divider #(.N(16)) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0h expected %0h", nm, what, act, exp);
      end
   endtask

   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov);
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      dz = (sb == 0);
      ov = (sa == -32768) && (sb == -1);
      if (dz) begin
         q = 16'hFFFF;
         r = a;
      end else begin
         q = 16'(sa / sb);
         r = 16'(sa % sb);
      end
   endfunction

   task automatic wait_done(output int e);
      e = 0;
      while (e < 40) begin
         @(posedge clk); #1;
         e++;
         if (bus.Done) break;
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic [15:0] r, input logic dz, input logic ov, input string nm);
      int e;
      int lat;
      lat = (b == 16'h0) ? 1 : 17;
      @(negedge clk);
      bus.start = 1'b1; bus.iDividend = a; bus.iDivisor = b;
      @(posedge clk); #1;
      chk(nm, "load_done", bus.Done, 0);
      chk(nm, "load_dz", bus.oDivZero, 0);
      chk(nm, "load_ov", bus.oOverflow, 0);
      chk(nm, "load_busy", bus.Busy, 1);
      chk(nm, "load_state", bus.oState, (b == 16'h0) ? 3 : 2);
      chk(nm, "load_count", bus.oCount, 0);
      @(negedge clk);
      bus.start = 1'b0; bus.iDividend = 16'($urandom); bus.iDivisor = 16'($urandom);
      e = 0;
      while (e < 40) begin
         @(posedge clk); #1;
         e++;
         if (bus.Done) break;
         chk(nm, "hold_q", bus.oQuotient, prev_q);
         chk(nm, "hold_r", bus.oRemainder, prev_r);
         chk(nm, "run_busy", bus.Busy, 1);
         chk(nm, "run_state", bus.oState, (e < 16) ? 2 : 3);
         if (e <= 16) chk(nm, "run_count", bus.oCount, e);
      end
      chk(nm, "latency", e, lat);
      chk(nm, "q", bus.oQuotient, q);
      chk(nm, "r", bus.oRemainder, r);
      chk(nm, "divzero", bus.oDivZero, dz);
      chk(nm, "overflow", bus.oOverflow, ov);
      chk(nm, "end_busy", bus.Busy, 0);
      chk(nm, "end_state", bus.oState, 1);
      prev_q = q;
      prev_r = r;
   endtask

   initial begin
      int e;
      logic [15:0] a, b, q, r;
      logic dz, ov;

      tbl[0] = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0};
      tbl[1] = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
      tbl[2] = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
      tbl[3] = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
      tbl[5] = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
      tbl[6] = '{16'd1234, 16'h0000, 16'hFFFF, 16'd1234, 1'b1, 1'b0};
      tbl[7] = '{16'd6,    16'd3,    16'h0002, 16'h0000, 1'b0, 1'b0};
      tbl[8] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
      tbl[9] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0};

      bus.start = 1'b0; bus.iDividend = '0; bus.iDivisor = '0;
      #12;
      chk("reset", "q", bus.oQuotient, 0);
      chk("reset", "r", bus.oRemainder, 0);
      chk("reset", "done", bus.Done, 0);
      chk("reset", "busy", bus.Busy, 0);
      chk("reset", "flags", {bus.oDivZero, bus.oOverflow}, 0);
      chk("reset", "state", bus.oState, 1);
      chk("reset", "count", bus.oCount, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle", "state", bus.oState, 1);

      for (int i = 0; i < 10; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, $sformatf("vec%0d", i));

      // Asynchronous reset in the middle of DIVIDE.
      @(negedge clk); bus.start = 1'b1; bus.iDividend = 16'd1000; bus.iDivisor = 16'd3;
      @(posedge clk);
      @(negedge clk); bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("midreset", "busy_before", bus.Busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midreset", "q", bus.oQuotient, 0);
      chk("midreset", "r", bus.oRemainder, 0);
      chk("midreset", "done", bus.Done, 0);
      chk("midreset", "busy", bus.Busy, 0);
      chk("midreset", "flags", {bus.oDivZero, bus.oOverflow}, 0);
      chk("midreset", "state", bus.oState, 1);
      chk("midreset", "count", bus.oCount, 0);
      prev_q = '0; prev_r = '0;
      @(negedge clk); rst_n = 1'b1;
      run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, "after_reset");

      // Start held high: back-to-back loads with operand changes mid-operation.
      @(negedge clk); bus.start = 1'b1; bus.iDividend = 16'd50; bus.iDivisor = 16'd5;
      @(posedge clk); #1;
      chk("b2b", "state1", bus.oState, 2);
      @(negedge clk); bus.iDividend = 16'd7; bus.iDivisor = 16'd9;
      wait_done(e);
      chk("b2b", "lat1", e, 17);
      chk("b2b", "q1", bus.oQuotient, 10);
      chk("b2b", "r1", bus.oRemainder, 0);
      @(posedge clk); #1;
      chk("b2b", "reload_done", bus.Done, 0);
      chk("b2b", "reload_busy", bus.Busy, 1);
      chk("b2b", "reload_state", bus.oState, 2);
      @(negedge clk); bus.iDividend = 16'd100; bus.iDivisor = 16'd3; bus.start = 1'b0;
      wait_done(e);
      chk("b2b", "lat2", e, 17);
      chk("b2b", "q2", bus.oQuotient, 0);
      chk("b2b", "r2", bus.oRemainder, 7);
      prev_q = 16'd0; prev_r = 16'd7;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       b = 16'h0000;
            1:       b = 16'h0001;
            2:       b = 16'hFFFF;
            3:       b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         a = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
         ref_div(a, b, q, r, dz, ov);
         run_op(a, b, q, r, dz, ov, $sformatf("rnd%0d_%0h_%0h", i, a, b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
